orient_bin_pipe: RTL and testbench

ORIENT_BIN_PIPE -- requirements
Module: orient_bin_pipe

---
 rtl/orient_bin_pipe_pkg.sv | 34 +++
 rtl/orient_bin_pipe_thresh_cmp.sv | 37 +++
 rtl/orient_bin_pipe.sv | 142 ++++++++++++++
 tb/tb_orient_bin_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/orient_bin_pipe_pkg.sv
// Shared constants for the orientation binning pipeline: bin count, tangent
// thresholds and the octant encoding used between stages.
package orient_bin_pipe_pkg;

  // tan(k*pi/32) for k = 0..7, scaled by 2^24; finer bin counts index a subset
  localparam int unsigned TAN_SCALE_BITS = 24;
  localparam int unsigned TAN_K32 [8] = '{
    0, 1652412, 3337196, 5089313, 6949350, 8967609, 11210177, 13768705
  };

  // {quadrant, upper-half-of-quadrant}; value equals the absolute octant number
  typedef enum logic [2:0] {
    OCT_0, OCT_1, OCT_2, OCT_3, OCT_4, OCT_5, OCT_6, OCT_7
  } octant_e;

  function automatic int unsigned nbins(input int unsigned bin_bits);
    return 32'd1 << bin_bits;
  endfunction

  // T[i] = round(tan(i*2*pi/NBINS) * 2^frac), valid for frac < 24
  function automatic int unsigned tan_thresh(input int unsigned i,
                                             input int unsigned bin_bits,
                                             input int unsigned frac);
    int unsigned k;
    k = i << (6 - bin_bits);
    return (TAN_K32[k[2:0]] + (32'd1 << (TAN_SCALE_BITS - 1 - frac)))
           >> (TAN_SCALE_BITS - frac);
  endfunction

  function automatic octant_e octant_of(input logic [1:0] quad, input logic upper);
    return octant_e'({quad, upper});
  endfunction

endpackage

// File: rtl/orient_bin_pipe_thresh_cmp.sv
// Counts how many tangent thresholds the ratio min/max reaches, and flags an
// exact hit so the mirrored octant can resolve the tie toward the higher bin.
module orient_thresh_cmp #(
  parameter int GW   = 9,
  parameter int FRAC = 12,
  parameter int NT   = 3,
  parameter int CW   = 2,
  parameter int NUSE = 3
) (
  input  logic [GW-1:0] mn_i,
  input  logic [GW-1:0] mx_i,
  input  logic [FRAC:0] thr_i [NT],
  output logic [CW-1:0] cnt_o,
  output logic          tie_o
);

  localparam int unsigned PW = GW + FRAC + 1;

  logic [PW-1:0] lhs;
  logic [PW-1:0] rhs [NT];

  assign lhs = PW'(mn_i) << FRAC;

  for (genvar g = 0; g < NT; g++) begin : g_prod
    assign rhs[g] = PW'(mx_i) * PW'(thr_i[g]);
  end

  always_comb begin
    cnt_o = '0;
    tie_o = 1'b0;
    for (int unsigned i = 0; i < NUSE; i++) begin
      if (lhs >= rhs[i]) cnt_o = cnt_o + CW'(1);
      if (lhs == rhs[i]) tie_o = 1'b1;
    end
  end

endmodule

// File: rtl/orient_bin_pipe.sv
// Three-stage gradient orientation quantiser: fold to a first-quadrant
// (along, across) pair, compare against tangent thresholds, unfold and rotate.
module orient_bin_pipe
  import orient_bin_pipe_pkg::*;
#(
  parameter int GW       = 9,
  parameter int BIN_BITS = 5,
  parameter int FRAC     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [GW-1:0]       dx,
  input  logic signed [GW-1:0]       dy,
  input  logic        [BIN_BITS-1:0] ref_bin,
  input  logic                       rot_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [BIN_BITS-1:0] bin,
  output logic                       zero_vec
);

  localparam int unsigned NB   = nbins(BIN_BITS);
  localparam int unsigned M    = NB / 8;
  localparam int unsigned NUSE = M - 1;
  localparam int unsigned NT   = (M > 1) ? M - 1 : 1;
  localparam int unsigned CW   = (BIN_BITS > 3) ? BIN_BITS - 3 : 1;

  logic [FRAC:0] thr [NT];
  for (genvar g = 0; g < NT; g++) begin : g_thr
    assign thr[g] = (FRAC+1)'(tan_thresh(g + 1, BIN_BITS, FRAC));
  end

  logic adv;
  logic v1_q, v2_q, v3_q;

  assign adv      = !(v3_q && !out_ready);
  assign in_ready = adv;

  // Stage 1: magnitudes and fold into quadrant-local (along=u, across=v)
  logic [GW-1:0] ax, ay, u, v, mn1_d, mx1_d;
  logic [1:0]    quad;
  logic          dx_pos, dy_pos, upper;
  octant_e       oct1_d;

  assign ax     = dx[GW-1] ? (~dx + 1'b1) : dx;
  assign ay     = dy[GW-1] ? (~dy + 1'b1) : dy;
  assign dx_pos = !dx[GW-1] && (dx != '0);
  assign dy_pos = !dy[GW-1] && (dy != '0);

  always_comb begin
    quad = 2'd3;
    u    = ay;
    v    = ax;
    if (!dy[GW-1] && dx_pos) begin
      quad = 2'd0; u = ax; v = ay;
    end else if (dy_pos && !dx_pos) begin
      quad = 2'd1; u = ay; v = ax;
    end else if (dx[GW-1] && !dy_pos) begin
      quad = 2'd2; u = ax; v = ay;
    end
    upper  = (v >= u);
    mn1_d  = upper ? u : v;
    mx1_d  = upper ? v : u;
    oct1_d = octant_of(quad, upper);
  end

  octant_e             oct1_q, oct2_q;
  logic [GW-1:0]       mn1_q, mx1_q;
  logic                zero1_q, zero2_q, zero3_q;
  logic [BIN_BITS-1:0] ref1_q, ref2_q;
  logic                rot1_q, rot2_q;
  logic [CW-1:0]       cnt2_d, cnt2_q;
  logic                tie2_d, tie2_q;
  logic [BIN_BITS-1:0] bin3_d, bin3_q;

  // Stage 2: threshold compare
  orient_thresh_cmp #(
    .GW   (GW),
    .FRAC (FRAC),
    .NT   (NT),
    .CW   (CW),
    .NUSE (NUSE)
  ) u_cmp (
    .mn_i  (mn1_q),
    .mx_i  (mx1_q),
    .thr_i (thr),
    .cnt_o (cnt2_d),
    .tie_o (tie2_d)
  );

  // Stage 3: mirrored octants count from the far edge; an exact tie there
  // belongs to the higher bin, hence the +tie.
  logic [CW-1:0]       sub;
  logic [BIN_BITS-1:0] abs_bin;

  always_comb begin
    sub     = oct2_q[0] ? (CW'(M - 1) - cnt2_q + CW'(tie2_q)) : cnt2_q;
    abs_bin = zero2_q ? '0
                      : ((BIN_BITS'(oct2_q) << (BIN_BITS - 3)) | BIN_BITS'(sub));
    bin3_d  = rot2_q ? (abs_bin - ref2_q) : abs_bin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      bin3_q  <= '0;
      zero3_q <= 1'b0;
    end else if (adv) begin
      v1_q    <= in_valid;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      bin3_q  <= bin3_d;
      zero3_q <= zero2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      oct1_q  <= oct1_d;
      mn1_q   <= mn1_d;
      mx1_q   <= mx1_d;
      zero1_q <= (dx == '0) && (dy == '0);
      ref1_q  <= ref_bin;
      rot1_q  <= rot_en;
      oct2_q  <= oct1_q;
      cnt2_q  <= cnt2_d;
      tie2_q  <= tie2_d;
      zero2_q <= zero1_q;
      ref2_q  <= ref1_q;
      rot2_q  <= rot1_q;
    end
  end

  assign out_valid = v3_q;
  assign bin       = bin3_q;
  assign zero_vec  = zero3_q;

endmodule

// File: tb/tb_orient_bin_pipe.sv
// Scoreboard bench for orient_bin_pipe at NBINS=32, GW=9, FRAC=12.
module tb_orient_bin_pipe;

  localparam int GW = 9;
  localparam int BB = 5;
  localparam int FR = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, rot_en, out_valid, out_ready, zero_vec;
  logic signed [GW-1:0] dx, dy;
  logic [BB-1:0]        ref_bin, bin;

  always #5 clk = ~clk;

  orient_bin_pipe #(.GW(GW), .BIN_BITS(BB), .FRAC(FR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dx        (dx),
    .dy        (dy),
    .ref_bin   (ref_bin),
    .rot_en    (rot_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .zero_vec  (zero_vec)
  );

  typedef struct {
    logic [5:0] ezb;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int          cyc    = 0;
  int          tq [4];
  bit          stalled_prev = 1'b0;
  logic [4:0]  prev_bin;
  logic        prev_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] golden(input int x0, input int y0, input int r, input bit ro);
    int x, y, t, base, cnt, ab;
    bit z;
    x = x0; y = y0; base = 0; ab = 0; cnt = 0;
    z = (x == 0) && (y == 0);
    if (!z) begin
      while (!(x > 0 && y >= 0)) begin
        t = x; x = y; y = -t; base += 8;
      end
      if (y < x) begin
        for (int i = 1; i < 4; i++) if (y * 4096 >= x * tq[i]) cnt++;
        ab = base + cnt;
      end else begin
        for (int i = 1; i < 4; i++) if (x * 4096 > y * tq[i]) cnt++;
        ab = base + 7 - cnt;
      end
    end
    if (ro) ab = (ab - r) & 31;
    return {z, ab[4:0]};
  endfunction

  task automatic step(input logic v, input logic signed [GW-1:0] x, input logic signed [GW-1:0] y,
                      input logic [4:0] r, input logic ro, input logic ordy,
                      input logic [5:0] ezb, input bit lat, output bit accepted);
    exp_t e;
    in_valid = v; dx = x; dy = y; ref_bin = r; rot_en = ro; out_ready = ordy;
    @(negedge clk);
    if (stalled_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_bin", bin, prev_bin);
      check("hold_zero", zero_vec, prev_zero);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("bin", bin, e.ezb[4:0]);
        check("zero_vec", zero_vec, e.ezb[5]);
        if (e.lat) check("latency", cyc - e.acc, 3);
      end
    end
    accepted = v && in_ready;
    if (accepted) begin
      e.ezb = ezb; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    stalled_prev = out_valid && !out_ready;
    prev_bin     = bin;
    prev_zero    = zero_vec;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0, a);
  endtask

  initial begin
    bit                   a;
    int                   idx;
    logic signed [GW-1:0] rx, ry;
    logic [4:0]           rr;
    logic                 rro;
    logic signed [GW-1:0] corner [5];
    logic signed [GW-1:0] bpx [8];

    for (int i = 1; i < 4; i++)
      tq[i] = int'($floor($tan(i * 2.0 * 3.14159265358979 / 32.0) * 4096.0 + 0.5));

    rst = 1'b1; in_valid = 1'b0; dx = '0; dy = '0; ref_bin = '0; rot_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bin", bin, 0);
    check("rst_zero", zero_vec, 0);
    rst = 1'b0;

    // axes with latency tracking
    step(1, 10, 0, 0, 0, 1, {1'b0, 5'd0}, 1, a);
    step(1, 0, 10, 0, 0, 1, {1'b0, 5'd8}, 1, a);
    step(1, -10, 0, 0, 0, 1, {1'b0, 5'd16}, 1, a);
    step(1, 0, -10, 0, 0, 1, {1'b0, 5'd24}, 1, a);
    // diagonals, extremes, wrap, zero vector
    step(1, 10, 10, 0, 0, 1, {1'b0, 5'd4}, 1, a);
    step(1, -256, -256, 0, 0, 1, {1'b0, 5'd20}, 1, a);
    step(1, 255, -1, 0, 0, 1, {1'b0, 5'd31}, 1, a);
    step(1, 10, 0, 1, 1, 1, {1'b0, 5'd31}, 1, a);
    step(1, 0, 0, 3, 1, 1, {1'b1, 5'd29}, 1, a);
    drain(5);

    // backpressure: out_ready low on cycles 4..7 of the burst
    for (int i = 0; i < 8; i++) bpx[i] = GW'(i * 30 - 100);
    idx = 0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      out_ready = !(k >= 4 && k <= 7);
      #1;
      if (k >= 4 && k <= 7) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
      end
      step(1, bpx[idx], GW'(7 - idx * 20), 5'(idx), 1'(idx % 2), out_ready,
           golden(int'(bpx[idx]), int'(GW'(7 - idx * 20)), idx, 1'(idx % 2)), 0, a);
      if (a) idx++;
    end
    check("bp_all_accepted", idx, 8);
    drain(6);

    // corner magnitudes through the golden model
    corner = '{-256, -1, 0, 1, 255};
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        step(1, corner[i], corner[j], 5'(i + j), 1'(j % 2), 1,
             golden(int'(corner[i]), int'(corner[j]), i + j, 1'(j % 2)), 1, a);
    drain(5);

    // random sweep with bubbles, backpressure and varying ref/rot
    for (int n = 0; n < 3000; n++) begin
      rx  = GW'($urandom_range(0, 511));
      ry  = GW'($urandom_range(0, 511));
      rr  = 5'($urandom_range(0, 31));
      rro = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 4) != 0), rx, ry, rr, rro, 1'($urandom_range(0, 3) != 0),
           golden(int'(rx), int'(ry), int'(rr), rro), 0, a);
    end
    drain(8);
    check("sb_empty_pre_rst", sb.size(), 0);

    // reset with three samples in flight
    step(1, 10, 0, 0, 0, 1, {1'b0, 5'd0}, 0, a);
    step(1, 0, 10, 0, 0, 1, {1'b0, 5'd8}, 0, a);
    step(1, -10, 0, 0, 0, 1, {1'b0, 5'd16}, 0, a);
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_bin", bin, 0);
    check("midrst_zero", zero_vec, 0);
    check("midrst_in_ready", in_ready, 1);
    sb.delete();
    stalled_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_valid", out_valid, 0);
      drain(1);
    end
    check("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
